// File: rtl/msrh_pkg.sv
// Shared types for the commit done-report path.
package msrh_pkg;

    localparam int CMT_BLK_W = 4;
    localparam int DISP_SIZE = 4;

    typedef struct packed {
        logic                 valid;
        logic [CMT_BLK_W-1:0] cmt_id;
        logic [DISP_SIZE-1:0] grp_id;
    } done_rpt_t;

    // Payload held in the overflow FIFO; valid is implied by occupancy.
    typedef struct packed {
        logic [CMT_BLK_W-1:0] cmt_id;
        logic [DISP_SIZE-1:0] grp_id;
    } cmp_req_t;

endpackage

// File: rtl/msrh_done_rpt_tx_if.sv
// Completion inputs, flush, backpressure and the done-report lane of one execution unit.
interface msrh_done_rpt_tx_if #(
    parameter int IN_PORTS = 2,
    parameter int DEPTH    = 4
);
    import msrh_pkg::*;

    logic [IN_PORTS-1:0]                cmp_valid;
    logic [IN_PORTS-1:0][CMT_BLK_W-1:0] cmp_cmt_id;
    logic [IN_PORTS-1:0][DISP_SIZE-1:0] cmp_grp_id;
    logic                               flush;
    logic                               ready;
    done_rpt_t                          done_rpt;
    logic [$clog2(DEPTH+1)-1:0]         count;

    modport master (
        output cmp_valid, cmp_cmt_id, cmp_grp_id, flush,
        input  ready, done_rpt, count
    );

    modport slave (
        input  cmp_valid, cmp_cmt_id, cmp_grp_id, flush,
        output ready, done_rpt, count
    );

endinterface

// File: rtl/msrh_multi_push_fifo.sv
// Circular buffer with up to IN_PORTS compacted pushes and one pop per cycle.
// DEPTH need not be a power of two; pushes beyond free space are dropped.
module msrh_multi_push_fifo
    import msrh_pkg::*;
#(
    parameter int IN_PORTS = 2,
    parameter int DEPTH    = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_flush,
    input  logic [IN_PORTS-1:0]         i_push_valid,
    input  cmp_req_t [IN_PORTS-1:0]     i_push_data,
    input  logic                        i_pop,
    output cmp_req_t                    o_head,
    output logic [$clog2(DEPTH+1)-1:0]  o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    cmp_req_t                       mem [DEPTH];
    logic [PTR_W-1:0]               head_q, tail_q;
    logic [CNT_W-1:0]               count_q;

    logic [IN_PORTS-1:0]            wr_en;
    logic [IN_PORTS-1:0][PTR_W-1:0] wr_idx;
    logic [CNT_W-1:0]               n_push;
    logic                           pop_ok;

    function automatic logic [PTR_W-1:0] wrap(input int unsigned v);
        wrap = PTR_W'(v % DEPTH);
    endfunction

    assign pop_ok = i_pop && (count_q != '0);

    // Assign consecutive tail slots to the valid pushes in port order, up to free space.
    always_comb begin
        int unsigned k;
        int unsigned free_slots;
        k          = 0;
        free_slots = DEPTH - int'(count_q) + (pop_ok ? 1 : 0);
        wr_en      = '0;
        wr_idx     = '0;
        for (int i = 0; i < IN_PORTS; i++) begin
            if (i_push_valid[i] && !i_flush && (k < free_slots)) begin
                wr_en[i]  = 1'b1;
                wr_idx[i] = wrap(int'(tail_q) + k);
                k         = k + 1;
            end
        end
        n_push = CNT_W'(k);
    end

    // Pointer and occupancy update; flush empties the buffer.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (i_flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= wrap(int'(head_q) + (pop_ok ? 1 : 0));
            tail_q  <= wrap(int'(tail_q) + int'(n_push));
            count_q <= count_q + n_push - CNT_W'(pop_ok);
        end
    end

    // Storage array carries no reset; occupancy decides what is meaningful.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < IN_PORTS; i++) begin
            if (wr_en[i]) mem[wr_idx[i]] <= i_push_data[i];
        end
    end

    assign o_head  = mem[head_q];
    assign o_count = count_q;

endmodule

// File: rtl/msrh_done_rpt_tx.sv
// Serialises multi-port completions onto one registered done-report lane,
// buffering the excess in age order and backpressuring issue via ready.
module msrh_done_rpt_tx
    import msrh_pkg::*;
#(
    parameter int IN_PORTS  = 2,
    parameter int DEPTH     = 4,
    parameter int CMT_BLK_W = msrh_pkg::CMT_BLK_W,
    parameter int DISP_SIZE = msrh_pkg::DISP_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    msrh_done_rpt_tx_if.slave    rpt_if
);

    localparam int IDX_W = (IN_PORTS > 1) ? $clog2(IN_PORTS) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    if (CMT_BLK_W != msrh_pkg::CMT_BLK_W || DISP_SIZE != msrh_pkg::DISP_SIZE) begin : g_width_chk
        $error("msrh_done_rpt_tx: id widths must match msrh_pkg");
    end

    cmp_req_t [IN_PORTS-1:0] in_req;
    logic [IN_PORTS-1:0]     push_valid;
    logic                    first_found;
    logic [IDX_W-1:0]        first_idx;
    logic                    fifo_empty;
    logic                    pop;
    logic                    any_cand;
    cmp_req_t                sel_req;
    cmp_req_t                fifo_head;
    logic [CNT_W-1:0]        fifo_count;
    done_rpt_t               done_q;

    // Pack per-port inputs into FIFO payloads.
    always_comb begin
        in_req = '0;
        for (int i = 0; i < IN_PORTS; i++) begin
            in_req[i].cmt_id = rpt_if.cmp_cmt_id[i];
            in_req[i].grp_id = rpt_if.cmp_grp_id[i];
        end
    end

    // Oldest candidate: FIFO head if any, else the lowest valid port; the rest go to the FIFO.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        for (int i = 0; i < IN_PORTS; i++) begin
            if (rpt_if.cmp_valid[i] && !first_found) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
        end
        fifo_empty = (fifo_count == '0);
        pop        = !fifo_empty && !rpt_if.flush;
        any_cand   = !rpt_if.flush && (!fifo_empty || first_found);
        sel_req    = '0;
        if (!fifo_empty)      sel_req = fifo_head;
        else if (first_found) sel_req = in_req[first_idx];
        push_valid = '0;
        for (int i = 0; i < IN_PORTS; i++) begin
            push_valid[i] = rpt_if.cmp_valid[i] && !rpt_if.flush
                            && !(fifo_empty && first_found && (first_idx == IDX_W'(i)));
        end
    end

    msrh_multi_push_fifo #(
        .IN_PORTS (IN_PORTS),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_flush      (rpt_if.flush),
        .i_push_valid (push_valid),
        .i_push_data  (in_req),
        .i_pop        (pop),
        .o_head       (fifo_head),
        .o_count      (fifo_count)
    );

    // Output register: one report per cycle, cleared on flush and when idle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            done_q <= '0;
        end else if (any_cand) begin
            done_q.valid  <= 1'b1;
            done_q.cmt_id <= sel_req.cmt_id;
            done_q.grp_id <= sel_req.grp_id;
        end else begin
            done_q <= '0;
        end
    end

    assign rpt_if.done_rpt = done_q;
    assign rpt_if.count    = fifo_count;
    assign rpt_if.ready    = ((DEPTH - int'(fifo_count)) >= IN_PORTS);

    // Protocol checks: one-hot groups, no duplicate reports per cycle, no push while not ready.
    always @(posedge i_clk) begin
        if (i_reset_n) begin
            for (int i = 0; i < IN_PORTS; i++) begin
                if (rpt_if.cmp_valid[i]) assert ($onehot(rpt_if.cmp_grp_id[i]));
                for (int j = i + 1; j < IN_PORTS; j++) begin
                    if (rpt_if.cmp_valid[i] && rpt_if.cmp_valid[j])
                        assert (in_req[i] != in_req[j]);
                end
            end
            assert (int'(fifo_count) <= DEPTH);
            assert (!(|rpt_if.cmp_valid) || rpt_if.ready || rpt_if.flush);
        end
    end

endmodule

// File: tb/tb_msrh_done_rpt_tx.sv
// Directed checks of the done-report transmitter with DEPTH=4, IN_PORTS=2.
module tb_msrh_done_rpt_tx;
    import msrh_pkg::*;

    logic i_clk = 1'b0;
    logic i_reset_n = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    msrh_done_rpt_tx_if #(.IN_PORTS(2), .DEPTH(4)) bus ();

    msrh_done_rpt_tx #(.IN_PORTS(2), .DEPTH(4)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .rpt_if    (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v0, input int c0, input int g0,
                         input logic v1, input int c1, input int g1);
        bus.cmp_valid     = {v1, v0};
        bus.cmp_cmt_id[0] = CMT_BLK_W'(c0);
        bus.cmp_grp_id[0] = DISP_SIZE'(g0);
        bus.cmp_cmt_id[1] = CMT_BLK_W'(c1);
        bus.cmp_grp_id[1] = DISP_SIZE'(g1);
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic expect_out(input string tag, input int v, input int c, input int g,
                              input int cnt, input int rdy);
        chk({tag, ".valid"}, bus.done_rpt.valid, v);
        if (v != 0) begin
            chk({tag, ".cmt"}, bus.done_rpt.cmt_id, c);
            chk({tag, ".grp"}, bus.done_rpt.grp_id, g);
        end
        chk({tag, ".count"}, bus.count, cnt);
        chk({tag, ".ready"}, bus.ready, rdy);
    endtask

    initial begin
        bus.flush = 1'b0;
        idle();
        #12;
        chk("rst.cmt", bus.done_rpt.cmt_id, 0);
        chk("rst.grp", bus.done_rpt.grp_id, 0);
        expect_out("rst", 0, 0, 0, 0, 1);
        i_reset_n = 1'b1;
        #20;

        // 1: single report, one-cycle latency
        drive(1'b1, 5, 4'b0010, 1'b0, 0, 0);
        step();
        idle();
        expect_out("t1.c1", 1, 5, 4'b0010, 0, 1);
        step();
        expect_out("t1.c2", 0, 0, 0, 0, 1);

        // 2: two ports same cycle, low port first
        drive(1'b1, 3, 4'b0001, 1'b1, 3, 4'b0100);
        step();
        idle();
        expect_out("t2.c1", 1, 3, 4'b0001, 1, 1);
        step();
        expect_out("t2.c2", 1, 3, 4'b0100, 0, 1);
        step();
        expect_out("t2.c3", 0, 0, 0, 0, 1);

        // 3: two consecutive double bursts
        drive(1'b1, 1, 4'b0001, 1'b1, 1, 4'b0010);
        step();
        expect_out("t3.c1", 1, 1, 4'b0001, 1, 1);
        drive(1'b1, 2, 4'b0001, 1'b1, 2, 4'b0010);
        step();
        idle();
        expect_out("t3.c2", 1, 1, 4'b0010, 2, 1);
        step();
        expect_out("t3.c3", 1, 2, 4'b0001, 1, 1);
        step();
        expect_out("t3.c4", 1, 2, 4'b0010, 0, 1);
        step();
        expect_out("t3.c5", 0, 0, 0, 0, 1);

        // 4: fill to 3, ready drops, drain; two rounds to cross the pointer wrap
        for (int r = 0; r < 2; r++) begin
            int b;
            b = 4 + 3 * r;
            for (int j = 0; j < 3; j++) begin
                drive(1'b1, b + j, 4'b0001, 1'b1, b + j, 4'b0010);
                step();
                expect_out($sformatf("t4.r%0d.f%0d", r, j), 1, b + j / 2,
                           (j % 2 == 0) ? 4'b0001 : 4'b0010, j + 1, (j + 1 <= 2) ? 1 : 0);
            end
            idle();
            for (int j = 3; j < 6; j++) begin
                step();
                expect_out($sformatf("t4.r%0d.d%0d", r, j), 1, b + j / 2,
                           (j % 2 == 0) ? 4'b0001 : 4'b0010, 5 - j, 1);
            end
            step();
            expect_out($sformatf("t4.r%0d.end", r), 0, 0, 0, 0, 1);
        end

        // 5: flush at count 3 with port 0 valid
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 10 + j, 4'b0001, 1'b1, 10 + j, 4'b0010);
            step();
        end
        expect_out("t5.pre", 1, 11, 4'b0001, 3, 0);
        drive(1'b1, 9, 4'b1000, 1'b0, 0, 0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        idle();
        expect_out("t5.c1", 0, 0, 0, 0, 1);
        step();
        expect_out("t5.c2", 0, 0, 0, 0, 1);

        // 6: async reset mid-burst at count 2, then single report latency
        drive(1'b1, 1, 4'b0001, 1'b1, 1, 4'b0010);
        step();
        drive(1'b1, 2, 4'b0001, 1'b1, 2, 4'b0010);
        step();
        expect_out("t6.pre", 1, 1, 4'b0010, 2, 1);
        #2;
        i_reset_n = 1'b0;
        #1;
        expect_out("t6.rst", 0, 0, 0, 0, 1);
        idle();
        #4;
        i_reset_n = 1'b1;
        drive(1'b1, 7, 4'b0100, 1'b0, 0, 0);
        step();
        idle();
        expect_out("t6.c1", 1, 7, 4'b0100, 0, 1);
        step();
        expect_out("t6.c2", 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
